// File: rtl/controller_mem_dt_seq_pkg.sv
// Shared codes for the sequenced data-stack access engine: stack commands, request ops, FSM states.
// Latency: none (constants only). Backpressure: n/a.
package controller_mem_dt_seq_pkg;

    localparam int SC_N = 2;

    typedef enum logic [SC_N-1:0] {
        SC_NON = 2'd0,
        SC_PUS = 2'd1,
        SC_POP = 2'd2
    } sc_cmd_e;

    typedef enum logic [1:0] {
        DQ_NOP = 2'd0,
        DQ_PUS = 2'd1,
        DQ_POP = 2'd2,
        DQ_REP = 2'd3
    } dq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2,
        ST_RESP = 2'd3
    } dt_state_e;

    // First busy state after a request is accepted.
    function automatic dt_state_e accept_next(input dq_op_e op, input logic cnt_zero);
        dt_state_e nxt;
        nxt = ST_RESP;
        case (op)
            DQ_PUS:  nxt = ST_PUSH;
            DQ_POP:  nxt = cnt_zero ? ST_RESP : ST_POP;
            DQ_REP:  nxt = cnt_zero ? ST_PUSH : ST_POP;
            default: nxt = ST_RESP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/controller_mem_dt_seq_occupancy.sv
// dt_occupancy: saturating up/down count of data-stack entries, only built with DT_GUARD_EN.
// Latency: count updates the edge after an SC_PUS/SC_POP cycle. Backpressure: none, full/empty are advisory.
`ifdef DT_GUARD_EN
module dt_occupancy #(
    parameter int DEPTH = 16,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            occ <= '0;
        end else if (inc && !dec && !full) begin
            occ <= occ + OCC_W'(1);
        end else if (dec && !inc && !empty) begin
            occ <= occ - OCC_W'(1);
        end
    end

endmodule
`endif

// File: rtl/controller_mem_dt_seq.sv
// Data-stack access engine: one push/pop-N/replace-N request per handshake -> SC_* command stream.
// Latency: NOP 1, PUSH 2, POP cnt+1, REPL cnt+2 cycles accept-to-rsp_valid. Backpressure: req_ready only in IDLE.
// Optional DT_GUARD_EN adds an occupancy guard and the occ output.
module controller_mem_dt_seq
    import controller_mem_dt_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3,
    parameter int DEPTH  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [CNT_W-1:0]  req_cnt,
    input  logic [DATA_W-1:0] req_data,
    output logic [SC_N-1:0]   dt_cmd,
    output logic [DATA_W-1:0] dt_data,
    input  logic [DATA_W-1:0] dt_q,
    input  logic              dt_empty,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
`ifdef DT_GUARD_EN
    output logic [$clog2(DEPTH+1)-1:0] occ,
`endif
    output logic              err
);

    dt_state_e         state;
    dq_op_e            op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_q;
    logic              pop_d;
    logic              err_q;

    logic              pop_block;
    logic              push_block;
    logic              pop_fire;
    logic              push_fire;

`ifdef DT_GUARD_EN
    logic occ_full;
    logic occ_empty;

    dt_occupancy #(
        .DEPTH (DEPTH)
    ) u_occ (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (push_fire),
        .dec   (pop_fire),
        .occ   (occ),
        .full  (occ_full),
        .empty (occ_empty)
    );

    assign pop_block  = dt_empty | occ_empty;
    assign push_block = occ_full;
`else
    assign pop_block  = dt_empty;
    assign push_block = 1'b0;
`endif

    // Commands decode from registered state plus the stack's live empty flag, so a pop
    // never lands on an entry that an earlier pop in the same burst already removed.
    assign pop_fire  = (state == ST_POP)  && !pop_block;
    assign push_fire = (state == ST_PUSH) && !push_block;

    always_comb begin
        dt_cmd = SC_NON;
        if (push_fire) begin
            dt_cmd = SC_PUS;
        end else if (pop_fire) begin
            dt_cmd = SC_POP;
        end
    end

    assign dt_data   = push_fire ? data_q : {DATA_W{1'bz}};
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign err       = err_q;

    // Popped data arrives one cycle after SC_POP; forward it so a POP ending straight
    // into RESP reports the final entry without an extra cycle.
    assign rsp_data  = pop_d ? dt_q : rsp_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            op_q   <= DQ_NOP;
            cnt_q  <= '0;
            data_q <= '0;
            rsp_q  <= '0;
            pop_d  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pop_d <= pop_fire;
            if (pop_d) begin
                rsp_q <= dt_q;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q   <= dq_op_e'(req_op);
                        cnt_q  <= req_cnt;
                        data_q <= req_data;
                        rsp_q  <= '0;
                        if (dq_op_e'(req_op) == DQ_NOP) begin
                            err_q <= 1'b0;
                        end
                        state <= accept_next(dq_op_e'(req_op), req_cnt == '0);
                    end
                end

                ST_POP: begin
                    if (pop_block) begin
                        err_q <= 1'b1;
                        cnt_q <= '0;
                        state <= (op_q == DQ_REP) ? ST_PUSH : ST_RESP;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                        if (cnt_q <= CNT_W'(1)) begin
                            state <= (op_q == DQ_REP) ? ST_PUSH : ST_RESP;
                        end
                    end
                end

                ST_PUSH: begin
                    if (push_block) begin
                        err_q <= 1'b1;
                    end
                    state <= ST_RESP;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
